weight_config_loader: RTL
=========================

WEIGHT_CONFIG_LOADER -- requirements
Module: weight_config_loader

Interface
REQ-001 SHALL have parameter NUM_NEURON, default 30: number of neurons in the target layer.
REQ-002 SHALL have parameter NUM_WEIGHT, default 30: weights per neuron.
REQ-003 SHALL have parameter NEURON_BASE, default 0: value of config_neuron_num for the first neuron.
REQ-004 SHALL have port clk  in  1: sole clock; all logic on posedge.
REQ-005 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-006 SHALL have port start  in  1: one-cycle load request; honoured only in IDLE.
REQ-007 SHALL have port layer_num  in  32: target layer number, sampled when start is honoured.
REQ-008 SHALL have port s_data  in  32: host word (weight or bias).
REQ-009 SHALL have port s_valid  in  1: s_data valid.
REQ-010 SHALL have port s_ready  out  1: loader accepts s_data this cycle.
REQ-011 SHALL have port weightValid  out  1: one-cycle weight write strobe to neurons.
REQ-012 SHALL have port biasValid  out  1: one-cycle bias write strobe to neurons.
REQ-013 SHALL have port weightValue  out  32: weight word.
REQ-014 SHALL have port biasValue  out  32: bias word.
REQ-015 SHALL have port config_layer_num  out  32: destination layer.
REQ-016 SHALL have port config_neuron_num  out  32: destination neuron.
REQ-017 SHALL have port busy  out  1: load in progress.
REQ-018 SHALL have port done  out  1: one-cycle pulse at load completion.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD_W, LOAD_B.
REQ-020 SHALL, in IDLE with start=1, latch layer_num, clear neuron counter n and weight counter w, and enter LOAD_W next cycle.
REQ-021 SHALL drive s_ready=1 exactly in LOAD_W and LOAD_B; busy=1 in LOAD_W and LOAD_B.
REQ-022 SHALL treat a word as accepted only when s_valid & s_ready; s_valid low stalls the FSM with counters held and no strobes.
REQ-023 SHALL, for a word accepted in LOAD_W, assert weightValid next cycle with weightValue=s_data, config_layer_num=latched layer, config_neuron_num=NEURON_BASE+n (1-cycle latency, all registered).
REQ-024 SHALL increment w per LOAD_W acceptance; on acceptance with w=NUM_WEIGHT-1, clear w and enter LOAD_B.
REQ-025 SHALL, for a word accepted in LOAD_B, assert biasValid next cycle with biasValue=s_data and the same config_layer_num/config_neuron_num as that neuron's weights.
REQ-026 SHALL, on LOAD_B acceptance with n<NUM_NEURON-1, increment n and return to LOAD_W.
REQ-027 SHALL, on LOAD_B acceptance with n=NUM_NEURON-1, enter IDLE and assert done in the same cycle as that final biasValid.
REQ-028 SHALL never assert weightValid and biasValid in the same cycle; each strobe lasts exactly one cycle per accepted word.
REQ-029 SHALL hold weightValue, biasValue, config_layer_num, config_neuron_num stable between strobes (update only with a strobe).
REQ-030 SHALL ignore start while busy=1; latched layer unchanged.
REQ-031 SHALL use counter widths $clog2(NUM_WEIGHT)+1 and $clog2(NUM_NEURON)+1 so terminal compares never wrap.

Reset
REQ-032 SHALL, on rst=1, enter IDLE and drive s_ready=0, busy=0, done=0, weightValid=0, biasValid=0, weightValue=0, biasValue=0, config_layer_num=0, config_neuron_num=0, n=0, w=0.
REQ-033 SHALL abandon any load on mid-operation reset with no further strobes; reset has priority over start and s_valid.

Verification
REQ-034 NUM_NEURON=2, NUM_WEIGHT=3, NEURON_BASE=0, start with layer_num=2, s_valid continuous with words 1..8 -> weightValid for 1,2,3 (neuron 0), biasValid for 4 (neuron 0), weightValid for 5,6,7 (neuron 1), biasValid+done for 8; config_layer_num=2 throughout; s_ready low after word 8.
REQ-035 Same config, s_valid deasserted for 3 cycles after word 2 -> no strobes during gap, word 3 still weight of neuron 0, total strobe sequence identical to REQ-034.
REQ-036 start pulsed again with layer_num=5 during LOAD_W -> ignored; config_layer_num stays 2; done after 8 words.
REQ-037 rst asserted after word 5 accepted -> next cycle all outputs 0, IDLE; new start with layer_num=3 and 8 words -> full correct sequence with neuron 0 restart.
REQ-038 NEURON_BASE=1, NUM_NEURON=1, NUM_WEIGHT=1, words 0xAAAA, 0x5555 -> weightValid value 0xAAAA neuron 1, then biasValid value 0x5555 neuron 1 with done.

Source files
------------

// File: rtl/weight_config_loader.sv
// Streams host words into a layer's neurons: NUM_WEIGHT weights then one bias per neuron,
// emitting one-cycle registered write strobes tagged with the destination layer and neuron.
module weight_config_loader #(
  parameter int unsigned NUM_NEURON  = 30,
  parameter int unsigned NUM_WEIGHT  = 30,
  parameter int unsigned NEURON_BASE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] layer_num,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        weightValid,
  output logic        biasValid,
  output logic [31:0] weightValue,
  output logic [31:0] biasValue,
  output logic [31:0] config_layer_num,
  output logic [31:0] config_neuron_num,
  output logic        busy,
  output logic        done
);

  localparam int unsigned WW = $clog2(NUM_WEIGHT) + 1;
  localparam int unsigned NW = $clog2(NUM_NEURON) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_B = 2'd2
  } state_t;

  state_t        state_q;
  logic [WW-1:0] w_q;
  logic [NW-1:0] n_q;
  logic [31:0]   layer_q;
  logic          weight_valid_q;
  logic          bias_valid_q;
  logic          done_q;
  logic [31:0]   weight_value_q;
  logic [31:0]   bias_value_q;
  logic [31:0]   cfg_layer_q;
  logic [31:0]   cfg_neuron_q;
  logic          accept;

  // Ready is a pure decode of the state register, so it is glitch-free and has no input path.
  assign s_ready = (state_q == LOAD_W) || (state_q == LOAD_B);
  assign busy    = s_ready;
  assign accept  = s_valid & s_ready;

  assign weightValid       = weight_valid_q;
  assign biasValid         = bias_valid_q;
  assign weightValue       = weight_value_q;
  assign biasValue         = bias_value_q;
  assign config_layer_num  = cfg_layer_q;
  assign config_neuron_num = cfg_neuron_q;
  assign done              = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      w_q            <= '0;
      n_q            <= '0;
      layer_q        <= '0;
      weight_valid_q <= 1'b0;
      bias_valid_q   <= 1'b0;
      done_q         <= 1'b0;
      weight_value_q <= '0;
      bias_value_q   <= '0;
      cfg_layer_q    <= '0;
      cfg_neuron_q   <= '0;
    end else begin
      weight_valid_q <= 1'b0;
      bias_valid_q   <= 1'b0;
      done_q         <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            layer_q <= layer_num;
            n_q     <= '0;
            w_q     <= '0;
            state_q <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (accept) begin
            weight_valid_q <= 1'b1;
            weight_value_q <= s_data;
            cfg_layer_q    <= layer_q;
            cfg_neuron_q   <= NEURON_BASE + 32'(n_q);
            if (w_q == WW'(NUM_WEIGHT - 1)) begin
              w_q     <= '0;
              state_q <= LOAD_B;
            end else begin
              w_q <= w_q + WW'(1);
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            bias_valid_q <= 1'b1;
            bias_value_q <= s_data;
            cfg_layer_q  <= layer_q;
            cfg_neuron_q <= NEURON_BASE + 32'(n_q);
            if (n_q == NW'(NUM_NEURON - 1)) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              n_q     <= n_q + NW'(1);
              state_q <= LOAD_W;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
